// File: rtl/std_dev_calc.sv
// std_dev_calc: snapshots nine samples, accumulates sum and sum of squares,
// then forms V = 9*sum(x^2) - sum(x)^2 and its floor square root bit-serially.
module std_dev_calc #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     count1,
    input  logic [DATA_W-1:0]     count2,
    input  logic [DATA_W-1:0]     count3,
    input  logic [DATA_W-1:0]     count4,
    input  logic [DATA_W-1:0]     count5,
    input  logic [DATA_W-1:0]     count6,
    input  logic [DATA_W-1:0]     count7,
    input  logic [DATA_W-1:0]     count8,
    input  logic [DATA_W-1:0]     count9,
    output logic                  busy,
    output logic                  valid,
    output logic [DATA_W+3:0]     sum,
    output logic [2*DATA_W+7:0]   var81,
    output logic [DATA_W+3:0]     std9
);

    localparam int SW = DATA_W + 4;
    localparam int QW = 2 * DATA_W + 4;
    localparam int VW = 2 * DATA_W + 8;
    localparam int RW = DATA_W + 4;

    typedef enum logic [2:0] {IDLE, ACCUM, VAR, SQRT, DONE} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   snap [9];
    logic [3:0]          idx;
    logic [5:0]          cnt;
    logic [SW-1:0]       s1;
    logic [QW-1:0]       s2;
    logic [VW-1:0]       v, v_n, rad;
    logic [RW+1:0]       rem;
    logic [RW-1:0]       root;
    logic [RW+3:0]       shifted, trial, diff;
    logic                ge, last;
    logic [DATA_W-1:0]   x;
    logic [2*DATA_W-1:0] sq;

    always_comb begin
        x       = snap[idx];
        sq      = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, x};
        v_n     = {{(VW-QW){1'b0}}, s2} * VW'(9) - {{(VW-SW){1'b0}}, s1} * {{(VW-SW){1'b0}}, s1};
        // Restoring root step: bring down two radicand bits, try subtracting 4*root+1
        shifted = {rem, rad[VW-1:VW-2]};
        trial   = {2'b00, root, 2'b01};
        diff    = shifted - trial;
        ge      = shifted >= trial;
        last    = cnt == 6'(RW - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? ACCUM : IDLE;
            ACCUM:      state_n = (idx == 4'd8) ? VAR : ACCUM;
            VAR:        state_n = SQRT;
            SQRT:       state_n = last ? DONE : SQRT;
            default:    state_n = IDLE;
        endcase
    end

    assign busy  = (state == ACCUM) || (state == VAR) || (state == SQRT);
    assign valid = state == DONE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            snap  <= '{default: '0};
            idx   <= '0;
            cnt   <= '0;
            s1    <= '0;
            s2    <= '0;
            v     <= '0;
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            sum   <= '0;
            var81 <= '0;
            std9  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        snap <= '{count1, count2, count3, count4, count5,
                                  count6, count7, count8, count9};
                        s1   <= '0;
                        s2   <= '0;
                        idx  <= '0;
                    end
                end
                ACCUM: begin
                    s1  <= s1 + {4'b0000, x};
                    s2  <= s2 + {4'b0000, sq};
                    idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
                end
                VAR: begin
                    v    <= v_n;
                    rad  <= v_n;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= '0;
                end
                SQRT: begin
                    rad  <= rad << 2;
                    rem  <= ge ? diff[RW+1:0] : shifted[RW+1:0];
                    root <= {root[RW-2:0], ge};
                    cnt  <= cnt + 6'd1;
                    // Publish on the final root bit so results coincide with DONE
                    if (last) begin
                        sum   <= s1;
                        var81 <= v;
                        std9  <= {root[RW-2:0], ge};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/std_dev_calc.md
# std_dev_calc

Statistics stage directly downstream of the nine-channel free-running counter bank. On a `start` strobe it snapshots the nine 32-bit counts and accumulates their sum and sum of squares sequentially. It then forms the scaled variance V = 9·Σx² − (Σx)² = 81·σ² and produces floor(√V) = floor(9·σ) with a bit-serial integer square root. Results are held until the next calculation completes.

## Interface
- `DATA_W`, 32, width of each input sample; all derived widths below assume 32.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `start`  in  1  request a calculation; accepted only when `busy` = 0.
- `count1` … `count9`  in  32 each  samples, captured on the accepting edge.
- `busy`  out  1  calculation in progress.
- `valid`  out  1  single-cycle pulse: new results on `sum`, `var81`, `std9`.
- `sum`  out  36  Σx.
- `var81`  out  72  V = 9·Σx² − (Σx)².
- `std9`  out  36  floor(√V).

## Operation
- Reset (`reset` = 0 at an edge): state IDLE; `busy`, `valid`, `sum`, `var81`, `std9`, internal accumulators and index all 0. Reset overrides everything, including mid-calculation; no partial result is ever published.
- States: IDLE → ACCUM → VAR → SQRT → DONE → IDLE.
- IDLE: if `start` = 1, latch count1..count9 into a 9-entry snapshot, clear S1/S2, set idx = 0, go to ACCUM.
- ACCUM (9 cycles): S1 += x[idx] (36 b); S2 += x[idx]² (68 b, one 32×32 multiply per cycle); idx increments 0..8; after idx = 8, go to VAR.
- VAR (1 cycle): V = 9·S2 − S1², computed in 72 b. V ≥ 0 always (Cauchy–Schwarz), so the result is treated as unsigned; no saturation is needed and no overflow can occur.
- SQRT (36 cycles): restoring square root, one result bit per cycle, MSB first. It uses a 72-bit radicand and a 38-bit remainder/trial path. The result is exact floor(√V).
- DONE (1 cycle): register `sum` = S1, `var81` = V, `std9` = root; return to IDLE.
- `start` while `busy` = 1 is ignored; it is not queued.
- Inputs count1..count9 are don't-care outside the accepting edge.
- Output registers change only at the DONE edge or at reset.

## Timing
- Edge E0 accepts `start`.
- `busy` = 1 from after E0 until after E46.
- ACCUM occupies edges E1–E9, VAR occupies E10, and SQRT occupies E11–E46.
- Results and `valid` = 1 appear after E46 (latency 46 cycles); `valid` drops after E47.
- `busy` = 0 in the `valid` cycle. A `start` in that cycle is accepted, giving back-to-back throughput of one result per 47 cycles.
- Reset asserted at any edge: the next cycle shows IDLE values, and `valid` never pulses for the aborted calculation.

## Test plan
- All samples = 5, start once → `valid` exactly 46 cycles after the accepting edge; `sum` = 45, `var81` = 0, `std9` = 0; `busy` high 46 cycles.
- Samples 1,2,…,9 → `sum` = 45, `var81` = 540, `std9` = 23.
- Samples 3,0,0,0,0,0,0,0,0 → `sum` = 3, `var81` = 72, `std9` = 8. Repeat with the 3 placed in count9 → identical results (index coverage).
- All samples = 0xFFFF_FFFF → `sum` = 0x8_FFFF_FFF7, `var81` = 0, `std9` = 0 (width/overflow check).
- Handshake sequence:
  - Pulse `start` again mid-SQRT → ignored, single `valid`.
  - Change count inputs after E0 → results unaffected.
  - Start in the `valid` cycle with new samples → second `valid` 47 cycles after the first.
- Assert `reset` = 0 during ACCUM, VAR and SQRT in separate runs → all outputs 0 the next cycle, no `valid` pulse. A fresh start after release gives correct results (e.g. samples 1..9 → `std9` = 23).
